// File: rtl/db_pkg.sv
// db_pkg: shared definitions for the luma deblocking blocks.
//   - pixel width and line packing offsets for {p3,p2,p1,p0,q0,q1,q2,q3}
//   - de decision encodings
//   - per-line gradient function (dp, dq, s, a)
package db_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned LINE_W = 8 * PIX_W;

    // Bit offsets of each pixel inside a packed line (p3 is the MSB pixel).
    localparam int unsigned P3_LSB = 56;
    localparam int unsigned P2_LSB = 48;
    localparam int unsigned P1_LSB = 40;
    localparam int unsigned P0_LSB = 32;
    localparam int unsigned Q0_LSB = 24;
    localparam int unsigned Q1_LSB = 16;
    localparam int unsigned Q2_LSB = 8;
    localparam int unsigned Q3_LSB = 0;

    typedef enum logic [1:0] {
        DE_OFF    = 2'd0,
        DE_NORMAL = 2'd1,
        DE_STRONG = 2'd2
    } de_e;

    typedef struct packed {
        logic [8:0] dp;  // |p2 - 2p1 + p0|
        logic [8:0] dq;  // |q2 - 2q1 + q0|
        logic [8:0] s;   // |p3 - p0| + |q0 - q3|
        logic [7:0] a;   // |p0 - q0|
    } grad_t;

    // |x2 - 2*x1 + x0|; the signed range is -510..510, so 10 bits suffice.
    function automatic logic [8:0] abs_2nd(input logic [7:0] x2, input logic [7:0] x1,
                                           input logic [7:0] x0);
        logic signed [9:0] v;
        v = $signed({2'b00, x2}) - $signed({1'b0, x1, 1'b0}) + $signed({2'b00, x0});
        if (v[9]) begin
            v = -v;
        end
        return v[8:0];
    endfunction

    function automatic logic [7:0] abs_diff(input logic [7:0] x, input logic [7:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    function automatic grad_t line_grad(input logic [LINE_W-1:0] l);
        grad_t g;
        logic [7:0] p3, p2, p1, p0, q0, q1, q2, q3;
        p3 = l[P3_LSB +: PIX_W];
        p2 = l[P2_LSB +: PIX_W];
        p1 = l[P1_LSB +: PIX_W];
        p0 = l[P0_LSB +: PIX_W];
        q0 = l[Q0_LSB +: PIX_W];
        q1 = l[Q1_LSB +: PIX_W];
        q2 = l[Q2_LSB +: PIX_W];
        q3 = l[Q3_LSB +: PIX_W];
        g.dp = abs_2nd(p2, p1, p0);
        g.dq = abs_2nd(q2, q1, q0);
        g.s  = {1'b0, abs_diff(p3, p0)} + {1'b0, abs_diff(q0, q3)};
        g.a  = abs_diff(p0, q0);
        return g;
    endfunction

endpackage

// File: rtl/db_lut_beta.sv
// db_lut_beta: qp -> beta lookup for luma deblocking.
//   i_qp   [5:0]  average luma qp
//   o_beta [6:0]  beta, 0 for qp outside 16..51
module db_lut_beta (
    input  logic [5:0] i_qp,
    output logic [6:0] o_beta
);

    // The table is linear in two pieces: qp-10 up to qp 28, then 2*qp-38 up to qp 51.
    always_comb begin
        o_beta = '0;
        if (i_qp >= 6'd16 && i_qp <= 6'd28) begin
            o_beta = {1'b0, i_qp} - 7'd10;
        end else if (i_qp >= 6'd29 && i_qp <= 6'd51) begin
            o_beta = {i_qp, 1'b0} - 7'd38;
        end
    end

endmodule

// File: rtl/db_edge_decision.sv
// db_edge_decision: luma deblocking edge decision over one 4-line segment.
//   clk, rst        clock, synchronous active-high reset
//   valid_i         one edge line on line_i this cycle
//   line_i [63:0]   {p3,p2,p1,p0,q0,q1,q2,q3}
//   qp_i, bs_i, tc_i  edge parameters, sampled on the line-0 beat
//   done_o          one-cycle pulse, decision valid
//   de_o [1:0]      0 off, 1 normal, 2 strong
//   dep_o, deq_o    filter p1 / q1 in normal mode
module db_edge_decision
    import db_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic [5:0]        qp_i,
    input  logic [1:0]        bs_i,
    input  logic [4:0]        tc_i,
    output logic              done_o,
    output logic [1:0]        de_o,
    output logic              dep_o,
    output logic              deq_o
);

    logic [1:0] r_line_cnt;
    logic [5:0] r_qp;
    logic [1:0] r_bs;
    logic [4:0] r_tc;
    grad_t      r_g0;
    logic       r_done;
    logic [1:0] r_de;
    logic       r_dep;
    logic       r_deq;

    grad_t       w_g;
    logic [6:0]  w_beta;
    logic [9:0]  w_dpq0;
    logic [9:0]  w_dpq3;
    logic [10:0] w_d;
    logic [6:0]  w_beta_d4;
    logic [6:0]  w_beta_d8;
    logic [6:0]  w_tc5;
    logic [7:0]  w_side_sum;
    logic [4:0]  w_side_lim;
    logic [9:0]  w_dp_sum;
    logic [9:0]  w_dq_sum;
    logic        w_on;
    logic        w_strong;
    logic [1:0]  w_de_nxt;
    logic        w_dep_nxt;
    logic        w_deq_nxt;

    db_lut_beta u_lut_beta (
        .i_qp   (r_qp),
        .o_beta (w_beta)
    );

    // Same gradient logic serves both the beat-0 capture and the beat-3 decision.
    assign w_g = line_grad(line_i);

    assign w_dpq0     = {1'b0, r_g0.dp} + {1'b0, r_g0.dq};
    assign w_dpq3     = {1'b0, w_g.dp} + {1'b0, w_g.dq};
    assign w_d        = {1'b0, w_dpq0} + {1'b0, w_dpq3};
    assign w_beta_d4  = {2'b00, w_beta[6:2]};
    assign w_beta_d8  = {3'b000, w_beta[6:3]};
    assign w_tc5      = {2'b00, r_tc} * 7'd5 + 7'd1;
    assign w_side_sum = {1'b0, w_beta} + {2'b00, w_beta[6:1]};
    assign w_side_lim = w_side_sum[7:3];
    assign w_dp_sum   = {1'b0, r_g0.dp} + {1'b0, w_g.dp};
    assign w_dq_sum   = {1'b0, r_g0.dq} + {1'b0, w_g.dq};

    assign w_on = (r_bs != 2'd0) && (w_d < {4'b0000, w_beta});

    assign w_strong = ({w_dpq0, 1'b0} < {4'b0000, w_beta_d4}) &&
                      ({w_dpq3, 1'b0} < {4'b0000, w_beta_d4}) &&
                      (r_g0.s < {2'b00, w_beta_d8}) &&
                      (w_g.s  < {2'b00, w_beta_d8}) &&
                      (r_g0.a < {2'b00, w_tc5[6:1]}) &&
                      (w_g.a  < {2'b00, w_tc5[6:1]});

    always_comb begin
        w_de_nxt  = DE_OFF;
        w_dep_nxt = 1'b0;
        w_deq_nxt = 1'b0;
        if (w_on) begin
            w_de_nxt  = w_strong ? DE_STRONG : DE_NORMAL;
            w_dep_nxt = w_dp_sum < {5'b00000, w_side_lim};
            w_deq_nxt = w_dq_sum < {5'b00000, w_side_lim};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_cnt <= '0;
            r_qp       <= '0;
            r_bs       <= '0;
            r_tc       <= '0;
            r_g0       <= '0;
            r_done     <= 1'b0;
            r_de       <= DE_OFF;
            r_dep      <= 1'b0;
            r_deq      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (valid_i) begin
                r_line_cnt <= r_line_cnt + 2'd1;
                if (r_line_cnt == 2'd0) begin
                    r_qp <= qp_i;
                    r_bs <= bs_i;
                    r_tc <= tc_i;
                    r_g0 <= w_g;
                end
                if (r_line_cnt == 2'd3) begin
                    r_done <= 1'b1;
                    r_de   <= w_de_nxt;
                    r_dep  <= w_dep_nxt;
                    r_deq  <= w_deq_nxt;
                end
            end
        end
    end

    assign done_o = r_done;
    assign de_o   = r_de;
    assign dep_o  = r_dep;
    assign deq_o  = r_deq;

endmodule

// File: tb/tb_db_edge_decision.sv
module tb_db_edge_decision;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [63:0] line_i;
    logic [5:0]  qp_i;
    logic [1:0]  bs_i;
    logic [4:0]  tc_i;
    logic        done_o;
    logic [1:0]  de_o;
    logic        dep_o;
    logic        deq_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int done_cyc[$];

    typedef struct {
        logic [1:0] de;
        logic       dep;
        logic       deq;
        string      tag;
    } exp_t;

    exp_t sb[$];

    db_edge_decision dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .line_i  (line_i),
        .qp_i    (qp_i),
        .bs_i    (bs_i),
        .tc_i    (tc_i),
        .done_o  (done_o),
        .de_o    (de_o),
        .dep_o   (dep_o),
        .deq_o   (deq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_done observed=1 expected=0 (cycle %0d)", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total += 3;
                assert (de_o === e.de) else begin
                    bad++;
                    $error("FAIL %s.de observed=%0d expected=%0d", e.tag, de_o, e.de);
                end
                assert (dep_o === e.dep) else begin
                    bad++;
                    $error("FAIL %s.dep observed=%0b expected=%0b", e.tag, dep_o, e.dep);
                end
                assert (deq_o === e.deq) else begin
                    bad++;
                    $error("FAIL %s.deq observed=%0b expected=%0b", e.tag, deq_o, e.deq);
                end
            end
        end
    end

    function automatic logic [63:0] pack(input int p3, input int p2, input int p1, input int p0,
                                         input int q0, input int q1, input int q2, input int q3);
        return {8'(p3), 8'(p2), 8'(p1), 8'(p0), 8'(q0), 8'(q1), 8'(q2), 8'(q3)};
    endfunction

    task automatic scramble();
        line_i = {$urandom, $urandom};
        qp_i   = 6'($urandom);
        bs_i   = 2'($urandom);
        tc_i   = 5'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [63:0] l, input logic [5:0] qp, input logic [1:0] bs,
                              input logic [4:0] tc);
        valid_i = 1'b1;
        line_i  = l;
        qp_i    = qp;
        bs_i    = bs;
        tc_i    = tc;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        scramble();
    endtask

    // Beats 1..2 carry random pixels, and beats 1..3 carry random qp/bs/tc.
    task automatic send_seg(input logic [63:0] l0, input logic [63:0] l3, input logic [5:0] qp,
                            input logic [1:0] bs, input logic [4:0] tc, input int gap,
                            input logic [1:0] de, input logic dep, input logic deq,
                            input string tag);
        exp_t e;
        drive_beat(l0, qp, bs, tc);
        idle(gap);
        drive_beat({$urandom, $urandom}, 6'($urandom), 2'($urandom), 5'($urandom));
        idle(gap);
        drive_beat({$urandom, $urandom}, 6'($urandom), 2'($urandom), 5'($urandom));
        idle(gap);
        e.de  = de;
        e.dep = dep;
        e.deq = deq;
        e.tag = tag;
        sb.push_back(e);
        exp_done++;
        drive_beat(l3, 6'($urandom), 2'($urandom), 5'($urandom));
    endtask

    // Called right after the beat-3 accept: pulse must be high now and gone a cycle later.
    task automatic check_pulse(input string tag);
        @(negedge clk);
        total++;
        assert (done_o === 1'b1) else begin
            bad++;
            $error("FAIL %s.latency observed=%0b expected=1", tag, done_o);
        end
        @(negedge clk);
        total++;
        assert (done_o === 1'b0) else begin
            bad++;
            $error("FAIL %s.pulse_width observed=%0b expected=0", tag, done_o);
        end
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        total += 4;
        assert (done_o === 1'b0) else begin
            bad++; $error("FAIL %s.done observed=%0b expected=0", tag, done_o);
        end
        assert (de_o === 2'd0) else begin
            bad++; $error("FAIL %s.de observed=%0d expected=0", tag, de_o);
        end
        assert (dep_o === 1'b0) else begin
            bad++; $error("FAIL %s.dep observed=%0b expected=0", tag, dep_o);
        end
        assert (deq_o === 1'b0) else begin
            bad++; $error("FAIL %s.deq observed=%0b expected=0", tag, deq_o);
        end
    endtask

    logic [63:0] flat;
    int          d0;
    int          d1;

    initial begin
        flat    = {8{8'd100}};
        rst     = 1'b1;
        valid_i = 1'b0;
        scramble();
        idle(3);
        rst = 1'b0;
        check_quiet("reset");

        send_seg(flat, flat, 6'd32, 2'd2, 5'd4, 0, 2'd2, 1'b1, 1'b1, "flat");
        check_pulse("flat");
        send_seg(flat, flat, 6'd32, 2'd0, 5'd4, 0, 2'd0, 1'b0, 1'b0, "bs0");
        check_pulse("bs0");
        send_seg(flat, flat, 6'd10, 2'd2, 5'd4, 0, 2'd0, 1'b0, 1'b0, "qp10");
        check_pulse("qp10");
        send_seg(pack(100, 100, 110, 100, 100, 100, 100, 100), flat, 6'd32, 2'd2, 5'd4, 0,
                 2'd1, 1'b0, 1'b1, "normal_p");
        check_pulse("normal_p");
        send_seg(flat, flat, 6'd32, 2'd2, 5'd4, 3, 2'd2, 1'b1, 1'b1, "gapped");
        check_pulse("gapped");

        // Reset after two beats discards the partial segment.
        drive_beat(flat, 6'd32, 2'd0, 5'd4);
        drive_beat(flat, 6'd32, 2'd0, 5'd4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_quiet("mid_reset");
        send_seg(flat, flat, 6'd32, 2'd2, 5'd4, 0, 2'd2, 1'b1, 1'b1, "after_reset");
        check_pulse("after_reset");

        // Reset coincident with the beat-3 accept: no pulse may follow.
        drive_beat(flat, 6'd32, 2'd2, 5'd4);
        drive_beat(flat, 6'd32, 2'd2, 5'd4);
        drive_beat(flat, 6'd32, 2'd2, 5'd4);
        rst = 1'b1;
        drive_beat(flat, 6'd32, 2'd2, 5'd4);
        rst = 1'b0;
        check_quiet("reset_beat3");
        idle(2);

        // Back-to-back segments.
        send_seg(flat, flat, 6'd32, 2'd2, 5'd4, 0, 2'd2, 1'b1, 1'b1, "b2b_a");
        send_seg(flat, flat, 6'd32, 2'd0, 5'd4, 0, 2'd0, 1'b0, 1'b0, "b2b_b");
        idle(3);
        total++;
        assert (done_cyc.size() >= 2) else begin
            bad++; $error("FAIL b2b.count observed=%0d expected>=2", done_cyc.size());
        end
        if (done_cyc.size() >= 2) begin
            d0 = done_cyc[done_cyc.size()-2];
            d1 = done_cyc[done_cyc.size()-1];
            total++;
            assert (d1 - d0 == 4) else begin
                bad++; $error("FAIL b2b.spacing observed=%0d expected=4", d1 - d0);
            end
        end

        // Beat-3 gradient path and threshold boundaries.
        send_seg(flat, pack(100, 100, 100, 100, 100, 100, 120, 100), 6'd32, 2'd2, 5'd4, 0,
                 2'd1, 1'b1, 1'b0, "normal_q3");
        check_pulse("normal_q3");
        send_seg(pack(100, 113, 100, 100, 100, 100, 100, 100),
                 pack(100, 100, 100, 100, 100, 100, 113, 100), 6'd32, 2'd2, 5'd4, 0,
                 2'd0, 1'b0, 1'b0, "d_eq_beta");
        check_pulse("d_eq_beta");
        send_seg(pack(100, 113, 100, 100, 100, 100, 100, 100),
                 pack(100, 100, 100, 100, 100, 100, 112, 100), 6'd32, 2'd2, 5'd4, 0,
                 2'd1, 1'b0, 1'b0, "d_lt_beta");
        check_pulse("d_lt_beta");
        send_seg(pack(103, 100, 100, 100, 100, 100, 100, 100), flat, 6'd32, 2'd2, 5'd4, 0,
                 2'd1, 1'b1, 1'b1, "s_eq_lim");
        check_pulse("s_eq_lim");
        send_seg(pack(102, 100, 100, 100, 100, 100, 100, 100), flat, 6'd32, 2'd2, 5'd4, 0,
                 2'd2, 1'b1, 1'b1, "s_lt_lim");
        check_pulse("s_lt_lim");
        send_seg(flat, pack(100, 100, 100, 100, 110, 110, 110, 110), 6'd32, 2'd2, 5'd4, 0,
                 2'd1, 1'b1, 1'b1, "a_eq_lim");
        check_pulse("a_eq_lim");
        send_seg(flat, pack(100, 100, 100, 100, 110, 110, 110, 110), 6'd32, 2'd2, 5'd5, 0,
                 2'd2, 1'b1, 1'b1, "a_tc5");
        check_pulse("a_tc5");
        send_seg(flat, flat, 6'd52, 2'd2, 5'd4, 0, 2'd0, 1'b0, 1'b0, "qp52");
        check_pulse("qp52");
        send_seg(flat, flat, 6'd16, 2'd2, 5'd4, 0, 2'd1, 1'b1, 1'b1, "qp16");
        check_pulse("qp16");
        send_seg(flat, flat, 6'd51, 2'd1, 5'd4, 0, 2'd2, 1'b1, 1'b1, "qp51");
        check_pulse("qp51");

        idle(4);
        total++;
        assert (sb.size() == 0) else begin
            bad++; $error("FAIL pending observed=%0d expected=0", sb.size());
        end
        total++;
        assert (done_cnt == exp_done) else begin
            bad++; $error("FAIL done_count observed=%0d expected=%0d", done_cnt, exp_done);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
